timer_scheduler: RTL and testbench
==================================

// Module: timer_scheduler
// PURPOSE
//  Shares one cycle_timer between NUM_REQUESTERS clients (port timeout / retry logic in the switch).
//  Round-robin arbitration; the winner's count loads into the timer, and the FSM runs it to expiry.
//  The owner then gets a one-cycle timeout pulse; the owner may cancel at any time.
//  Saves one counter per port. Only one timeout is active at a time.
// PARAMETERS
//  NUM_REQUESTERS  4   number of clients, >=2
//  BIT_WIDTH       16  timer count width, passed to cycle_timer
// PORTS
//  clock            in   1                          single clock, rising edge
//  reset_n          in   1                          asynchronous active-low reset
//  request_valid    in   NUM_REQUESTERS             client i wants a timeout
//  request_count    in   NUM_REQUESTERS*BIT_WIDTH   slice i = count for client i
//  request_ready    out  NUM_REQUESTERS             one-hot grant (combinational)
//  cancel           in   NUM_REQUESTERS             abort the running timeout; honoured only from the owner
//  timeout_expired  out  NUM_REQUESTERS             one-cycle pulse to the owner on expiry (registered)
//  busy             out  1                          timer owned, state != IDLE (registered)
//  owner            out  $clog2(NUM_REQUESTERS)     index of the current or last owner (registered)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; timeout_expired=0; busy=0; owner=0.
//   - rr pointer=NUM_REQUESTERS-1, so client 0 wins first.
//   - cycle_timer.reset_n is tied to reset_n.
//  FSM states IDLE, LOAD, RUN:
//   - IDLE:
//     - request_ready = round-robin pick among request_valid, searching from ptr+1 and wrapping.
//     - At most one bit is set, and only in IDLE; it is all-zero in other states.
//     - Handshake valid&ready in cycle g: capture count, owner<=i, ptr<=i, busy<=1, go to LOAD.
//   - LOAD:
//     - Timer enable=1, load_count=1, count=captured value.
//     - Next state RUN, unless cancel[owner]=1, which goes to IDLE.
//   - RUN:
//     - Timer enable = !timer.expired; load_count=0.
//     - When timer.expired=1: timeout_expired[owner]<=1 for one cycle, busy<=0, go to IDLE.
//   - The timer.expired input is ignored in IDLE and LOAD; a LOAD always clears any stale expired.
//  Latency:
//   - Accept at cycle g with count C gives timeout_expired[owner] high in exactly cycle g+C+4.
//   - This holds for every C in 0..2^BIT_WIDTH-1; C=0 gives g+4. No wrap-around.
//  IDLE is re-entered in the pulse cycle, so a new grant can occur in the same cycle as the pulse.
//  Cancel:
//   - cancel[owner] in LOAD or RUN goes to IDLE next cycle: busy<=0, no timeout_expired pulse.
//   - The timer's residual count is irrelevant; the next LOAD overwrites it.
//  Priority and ignored inputs:
//   - cancel[owner] and timer.expired in the same RUN cycle: cancel wins, no pulse.
//   - cancel from a non-owner, or any cancel in IDLE, is ignored.
//   - Clients withdraw pending requests by deasserting request_valid.
//  Request rules:
//   - Clients hold request_valid and request_count stable until ready.
//   - Dropping valid before ready is legal; the request is simply not granted.
//  Reset mid-operation: outputs clear immediately and any running timeout is lost silently.
// STRUCTURE
//  timer_scheduler_pkg:
//   - typedef enum logic[1:0] {IDLE, LOAD, RUN} timer_scheduler_state_t.
//   - function rr_pick(valid, ptr) returning a one-hot grant.
//  Sub-module: one instance of cycle_timer #(.BIT_WIDTH(BIT_WIDTH)).
//  Logic structure:
//   - Combinational next-state block.
//   - Single always_ff @(posedge clock or negedge reset_n) register block.
// TESTING
//  1. Client 1 alone, count=5, accepted cycle g -> timeout_expired=4'b0010 only in g+9; busy high g+1..g+8.
//  2. Client 0, count=0 -> pulse at g+4; a client-2 request held since g is granted in cycle g+4.
//  3. Clients 0,1,2 valid continuously, count=3 -> grant order 0,1,2,0,1.
//     - Grants 7 cycles apart (one per count+4 cycles); client 3 never granted.
//  4. Client 3, count=100, cancel[3] at g+20 -> busy=0 at g+21, no pulse ever.
//     - cancel[1] in the same run is ignored.
//  5. Count=10, cancel[owner] in the cycle timer.expired first rises (g+13) -> no pulse; busy=0 at g+14.
//  6. reset_n low mid-RUN -> all outputs 0 within the same cycle.
//     - After release, client 0 wins first and repeats scenario 1 timing.

Source files
------------

// File: rtl/timer_scheduler_pkg.sv
// Shared types and the round-robin picker for the timer scheduler.
package timer_scheduler_pkg;

  localparam int MAX_REQUESTERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } timer_scheduler_state_t;

  // One-hot grant of the first valid client after ptr, wrapping within n clients.
  function automatic logic [MAX_REQUESTERS-1:0] rr_pick(
    input logic [MAX_REQUESTERS-1:0] valid,
    input int                        ptr,
    input int                        n
  );
    logic [MAX_REQUESTERS-1:0] grant;
    logic                      found;
    int                        idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQUESTERS; k++) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && valid[idx[4:0]]) begin
          grant[idx[4:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/timer_scheduler_cycle_timer.sv
// Loadable down-counter; expired rises the cycle after the count reaches zero
// and stays high until the next load.
module cycle_timer #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 load_count,
  input  logic [BIT_WIDTH-1:0] count,
  output logic                 expired
);

  logic [BIT_WIDTH-1:0] remaining;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      expired   <= 1'b0;
    end else if (enable) begin
      if (load_count) begin
        remaining <= count;
        expired   <= 1'b0;
      end else if (remaining == '0) begin
        expired <= 1'b1;
      end else begin
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin sharing of one cycle_timer between several timeout clients.
// state | meaning
// IDLE  | timer free; grant offered to the round-robin winner
// LOAD  | captured count being loaded into the timer
// RUN   | timer counting down for the owner
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int BIT_WIDTH      = 16
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_REQUESTERS-1:0]           request_valid,
  input  logic [NUM_REQUESTERS*BIT_WIDTH-1:0] request_count,
  output logic [NUM_REQUESTERS-1:0]           request_ready,
  input  logic [NUM_REQUESTERS-1:0]           cancel,
  output logic [NUM_REQUESTERS-1:0]           timeout_expired,
  output logic                                busy,
  output logic [$clog2(NUM_REQUESTERS)-1:0]   owner
);

  localparam int OW = $clog2(NUM_REQUESTERS);

  timer_scheduler_state_t    state, state_next;
  logic [OW-1:0]             ptr, grant_idx;
  logic [BIT_WIDTH-1:0]      count_q, grant_count;
  logic [MAX_REQUESTERS-1:0] valid_ext, pick;
  logic                      grant_any, owner_cancel;
  logic                      timer_enable, timer_load, timer_expired;

  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQUESTERS-1:0] = request_valid;
    pick          = rr_pick(valid_ext, int'(ptr), NUM_REQUESTERS);
    request_ready = (state == IDLE) ? pick[NUM_REQUESTERS-1:0] : '0;
    grant_any     = |request_ready;
    grant_idx     = '0;
    grant_count   = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (request_ready[i]) begin
        grant_idx   = OW'(i);
        grant_count = request_count[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  assign owner_cancel = cancel[owner];
  assign timer_load   = (state == LOAD);
  assign timer_enable = timer_load || (state == RUN && !timer_expired);

  // Owner cancel outranks a simultaneous expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = LOAD;
      LOAD:    state_next = owner_cancel ? IDLE : RUN;
      RUN:     if (owner_cancel || timer_expired) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= OW'(NUM_REQUESTERS - 1);
      owner           <= '0;
      busy            <= 1'b0;
      timeout_expired <= '0;
      count_q         <= '0;
    end else begin
      state           <= state_next;
      timeout_expired <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            count_q <= grant_count;
            owner   <= grant_idx;
            ptr     <= grant_idx;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (owner_cancel) busy <= 1'b0;
        end
        RUN: begin
          if (owner_cancel) begin
            busy <= 1'b0;
          end else if (timer_expired) begin
            timeout_expired[owner] <= 1'b1;
            busy                   <= 1'b0;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  cycle_timer #(.BIT_WIDTH(BIT_WIDTH)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (timer_enable),
    .load_count (timer_load),
    .count      (count_q),
    .expired    (timer_expired)
  );

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler: a cycle-level reference model predicts
// grants, busy, owner and timeout pulses from the arbitration and latency rules.
module tb_timer_scheduler;

  localparam int N  = 4;
  localparam int BW = 16;

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    request_valid;
  logic [N*BW-1:0] request_count;
  logic [N-1:0]    request_ready;
  logic [N-1:0]    cancel;
  logic [N-1:0]    timeout_expired;
  logic            busy;
  logic [1:0]      owner;

  timer_scheduler #(.NUM_REQUESTERS(N), .BIT_WIDTH(BW)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .request_valid   (request_valid),
    .request_count   (request_count),
    .request_ready   (request_ready),
    .cancel          (cancel),
    .timeout_expired (timeout_expired),
    .busy            (busy),
    .owner           (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int due;
    int idx;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] hs_mask = '0;
  logic [N-1:0] sticky  = '0;

  int m_ptr   = N - 1;
  int m_owner = 0;
  int free_at = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model and monitor, evaluated mid-cycle once inputs have settled.
  always @(negedge clock) begin
    logic [N-1:0] exp_ready;
    int           widx;
    int           idx;
    int           c;
    hs_mask = request_valid & request_ready;
    if (!reset_n) begin
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_timeout", 32'(timeout_expired), 32'd0);
      check("reset_owner", 32'(owner), 32'd0);
      q.delete();
      m_ptr   = N - 1;
      m_owner = 0;
      free_at = 0;
    end else begin
      exp_ready = '0;
      widx      = -1;
      if (cyc >= free_at) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_ptr + k) % N;
          if (widx < 0 && request_valid[idx]) widx = idx;
        end
      end
      if (widx >= 0) exp_ready[widx] = 1'b1;
      check("ready", 32'(request_ready), 32'(exp_ready));
      check("busy", 32'(busy), (cyc < free_at) ? 32'd1 : 32'd0);
      check("owner", 32'(owner), 32'(m_owner));

      if (timeout_expired != '0) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", 32'(timeout_expired), 32'd0);
        end else begin
          check("pulse_cycle", 32'(cyc), 32'(q[0].due));
          check("pulse_owner", 32'(timeout_expired), 32'(1 << q[0].idx));
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        check("missing_pulse", 32'(timeout_expired), 32'(1 << q[0].idx));
        void'(q.pop_front());
      end

      if (cyc < free_at && cancel[m_owner]) begin
        free_at = cyc + 1;
        q.delete();
      end else if (widx >= 0) begin
        c       = int'(request_count[widx*BW +: BW]);
        m_ptr   = widx;
        m_owner = widx;
        free_at = cyc + c + 4;
        q.push_back('{due: cyc + c + 4, idx: widx});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    request_valid = (request_valid & ~hs_mask) | sticky;
  endtask

  task automatic set_req(input int i, input int c);
    request_valid[i] = 1'b1;
    request_count[i*BW +: BW] = 16'(c);
  endtask

  initial begin
    reset_n       = 1'b1;
    request_valid = '0;
    request_count = '0;
    cancel        = '0;
    #1 reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();

    set_req(1, 5);
    repeat (14) step();

    set_req(0, 0);
    step();
    set_req(2, 7);
    repeat (16) step();

    for (int i = 0; i < 3; i++) request_count[i*BW +: BW] = 16'd3;
    sticky = 4'b0111;
    request_valid = sticky;
    repeat (38) step();
    sticky = '0;
    request_valid = '0;
    repeat (10) step();

    set_req(3, 100);
    repeat (10) step();
    cancel = 4'b0010;
    step();
    cancel = '0;
    repeat (9) step();
    cancel = 4'b1000;
    step();
    cancel = '0;
    repeat (110) step();

    set_req(0, 10);
    repeat (13) step();
    cancel = 4'b0001;
    step();
    cancel = '0;
    repeat (5) step();

    set_req(1, 5);
    repeat (6) step();
    #1 reset_n = 1'b0;
    request_valid = '0;
    step();
    reset_n = 1'b1;
    set_req(0, 5);
    set_req(1, 5);
    repeat (24) step();

    repeat (3000) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!request_valid[i]) begin
          if ($urandom_range(3) == 0) set_req(i, int'($urandom_range(12)));
        end else if ($urandom_range(15) == 0) begin
          request_valid[i] = 1'b0;
        end
        cancel[i] = ($urandom_range(23) == 0);
      end
    end

    request_valid = '0;
    cancel        = '0;
    repeat (20) step();
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
